// File: rtl/debounce_pkg.sv
// Shared types and elaboration helpers for the debounce bank.
// Cycle counts are derived in 64-bit arithmetic so large clocks/times cannot overflow.
package debounce_pkg;

    typedef enum logic [2:0] {
        ST_RELEASED,
        ST_PRESS_PEND,
        ST_PRESSED,
        ST_HELD,
        ST_RELEASE_PEND
    } db_state_t;

    localparam longint unsigned MAX_CYC = 64'h0000_0000_7FFF_FFFF;

    function automatic longint unsigned ms_to_cycles(input longint unsigned freq,
                                                     input longint unsigned ms);
        return (freq / 64'd1000) * ms;
    endfunction

    // Bits needed to hold 0..cyc, never less than one.
    function automatic int cnt_width(input longint unsigned cyc);
        int w;
        w = 1;
        while ((64'd1 << w) < (cyc + 64'd1)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: polarity fix, two-flop synchroniser, qualification FSM
// with stable and hold counters, registered level and single-cycle event pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYC = 4,
    parameter int unsigned LONG_CYC   = 10,
    parameter int          SW         = 3,
    parameter int          HW         = 4,
    parameter logic        INVERT     = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pin_i,
    output logic result_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o
);

    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYC - 1);
    localparam logic [HW-1:0] LONG_LAST   = (LONG_CYC == 0) ? '0 : HW'(LONG_CYC - 1);
    localparam bit            LONG_EN     = (LONG_CYC != 0);
    localparam logic [SW-1:0] S_ONE       = SW'(1);
    localparam logic [HW-1:0] H_ONE       = HW'(1);

    logic            sync1_q, sync2_q;
    db_state_t       state_q, state_d;
    logic [SW-1:0]   stable_q, stable_d, stable_inc;
    logic [HW-1:0]   hold_q, hold_d, hold_inc;
    logic            fired_q, fired_d;
    logic            result_q, result_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            long_q, long_d;
    logic            s;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pin_i ^ INVERT;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;

    // Counters hold at all-ones instead of wrapping.
    assign stable_inc = (stable_q == '1) ? stable_q : stable_q + S_ONE;
    assign hold_inc   = (hold_q == '1)   ? hold_q   : hold_q + H_ONE;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_RELEASED;
            stable_q  <= '0;
            hold_q    <= '0;
            fired_q   <= 1'b0;
            result_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            stable_q  <= stable_d;
            hold_q    <= hold_d;
            fired_q   <= fired_d;
            result_q  <= result_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        stable_d  = stable_q;
        hold_d    = hold_q;
        fired_d   = fired_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        unique case (state_q)
            ST_RELEASED: begin
                if (s) begin
                    state_d  = ST_PRESS_PEND;
                    stable_d = '0;
                end
            end
            ST_PRESS_PEND: begin
                if (!s) begin
                    state_d = ST_RELEASED;
                end else if (stable_q == STABLE_LAST) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                    hold_d  = '0;
                    fired_d = 1'b0;
                end else begin
                    stable_d = stable_inc;
                end
            end
            ST_PRESSED: begin
                if (!s) begin
                    state_d  = ST_RELEASE_PEND;
                    stable_d = '0;
                end else begin
                    hold_d = hold_inc;
                    if (LONG_EN && (hold_q == LONG_LAST)) begin
                        state_d = ST_HELD;
                        long_d  = 1'b1;
                        fired_d = 1'b1;
                    end
                end
            end
            ST_HELD: begin
                if (!s) begin
                    state_d  = ST_RELEASE_PEND;
                    stable_d = '0;
                end
            end
            ST_RELEASE_PEND: begin
                // A bounce back to pressed resumes where it left off; the hold
                // count is frozen while pending so long-press is not re-armed.
                if (s) begin
                    state_d = fired_q ? ST_HELD : ST_PRESSED;
                end else if (stable_q == STABLE_LAST) begin
                    state_d   = ST_RELEASED;
                    release_d = 1'b1;
                end else begin
                    stable_d = stable_inc;
                end
            end
            default: begin
                state_d = ST_RELEASED;
            end
        endcase
        result_d = (state_d == ST_PRESSED) || (state_d == ST_HELD) ||
                   (state_d == ST_RELEASE_PEND);
    end

    assign result_o     = result_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounce channels sharing one timing configuration.
// Converts ms timing to clock cycles and rejects unrepresentable settings at elaboration.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int                  CHANNELS  = 4,
    parameter int unsigned         CLK_FREQ  = 100_000_000,
    parameter int unsigned         STABLE_MS = 50,
    parameter int unsigned         LONG_MS   = 1000,
    parameter logic [CHANNELS-1:0] INVERT    = '0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [CHANNELS-1:0] button_i,
    output logic [CHANNELS-1:0] result_o,
    output logic [CHANNELS-1:0] press_o,
    output logic [CHANNELS-1:0] release_o,
    output logic [CHANNELS-1:0] long_press_o
);

    localparam longint unsigned STABLE_CYC64 = ms_to_cycles(64'(CLK_FREQ), 64'(STABLE_MS));
    localparam longint unsigned LONG_CYC64   = ms_to_cycles(64'(CLK_FREQ), 64'(LONG_MS));
    localparam int unsigned     STABLE_CYC   = STABLE_CYC64[31:0];
    localparam int unsigned     LONG_CYC     = LONG_CYC64[31:0];
    localparam int              SW           = cnt_width(STABLE_CYC64);
    localparam int              HW           = cnt_width(LONG_CYC64);

    if (CHANNELS < 1) begin : g_err_channels
        $error("debounce_bank: CHANNELS must be at least 1");
    end
    if (STABLE_CYC64 == 64'd0) begin : g_err_stable_zero
        $error("debounce_bank: stable time rounds to zero clock cycles");
    end
    if (STABLE_CYC64 > MAX_CYC) begin : g_err_stable_big
        $error("debounce_bank: stable time exceeds 2^31-1 clock cycles");
    end
    if (LONG_CYC64 > MAX_CYC) begin : g_err_long_big
        $error("debounce_bank: long-press time exceeds 2^31-1 clock cycles");
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .STABLE_CYC (STABLE_CYC),
            .LONG_CYC   (LONG_CYC),
            .SW         (SW),
            .HW         (HW),
            .INVERT     (INVERT[g])
        ) u_ch (
            .clk_i        (clk_i),
            .reset_i      (reset_i),
            .pin_i        (button_i[g]),
            .result_o     (result_o[g]),
            .press_o      (press_o[g]),
            .release_o    (release_o[g]),
            .long_press_o (long_press_o[g])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with STABLE_CYC=4, LONG_CYC=10, channel 3 active-low.
// Cycle c counts posedges from the first edge that samples a pin change (c=0).
module tb_debounce_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] button;
    logic [3:0] result, press, rel, lp;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    debounce_bank #(
        .CHANNELS  (4),
        .CLK_FREQ  (1000),
        .STABLE_MS (4),
        .LONG_MS   (10),
        .INVERT    (4'b1000)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .button_i     (button),
        .result_o     (result),
        .press_o      (press),
        .release_o    (rel),
        .long_press_o (lp)
    );

    task automatic test_reset;
        reset  = 1'b1;
        button = 4'b1000;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({result, press, rel, lp} !== 16'h0) begin
            errors++;
            $display("FAIL reset_hold got r=%b p=%b rl=%b l=%b exp all 0", result, press, rel, lp);
        end
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({result, press, rel, lp} !== 16'h0) begin
                errors++;
                $display("FAIL reset_idle c=%0d got r=%b p=%b rl=%b l=%b exp all 0",
                         c, result, press, rel, lp);
            end
        end
    endtask

    task automatic test_clean_press;
        logic [3:0] er, ep, erl;
        button[0] = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            @(posedge clk); #1;
            er = (c >= 6) ? 4'b0001 : 4'b0000;
            ep = (c == 6) ? 4'b0001 : 4'b0000;
            checks++;
            if ({result, press, rel, lp} !== {er, ep, 4'b0000, 4'b0000}) begin
                errors++;
                $display("FAIL clean_press c=%0d got r=%b p=%b rl=%b l=%b exp r=%b p=%b rl=0000 l=0000",
                         c, result, press, rel, lp, er, ep);
            end
        end
        button[0] = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            @(posedge clk); #1;
            er  = (c < 6) ? 4'b0001 : 4'b0000;
            erl = (c == 6) ? 4'b0001 : 4'b0000;
            checks++;
            if ({result, press, rel, lp} !== {er, 4'b0000, erl, 4'b0000}) begin
                errors++;
                $display("FAIL clean_release c=%0d got r=%b p=%b rl=%b l=%b exp r=%b p=0000 rl=%b l=0000",
                         c, result, press, rel, lp, er, erl);
            end
        end
    endtask

    task automatic test_bounce;
        logic [3:0] er, ep;
        for (int c = 0; c <= 12; c++) begin
            button[1] = (c == 3) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            er = (c >= 10) ? 4'b0010 : 4'b0000;
            ep = (c == 10) ? 4'b0010 : 4'b0000;
            checks++;
            if ({result, press, rel, lp} !== {er, ep, 4'b0000, 4'b0000}) begin
                errors++;
                $display("FAIL bounce c=%0d got r=%b p=%b rl=%b l=%b exp r=%b p=%b rl=0000 l=0000",
                         c, result, press, rel, lp, er, ep);
            end
        end
        button[1] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (result !== 4'b0000) begin
            errors++;
            $display("FAIL bounce_settle got r=%b exp r=0000", result);
        end
    endtask

    task automatic test_long_press;
        logic [3:0] er, ep, erl, el;
        for (int c = 0; c <= 40; c++) begin
            button[2] = (c < 30);
            @(posedge clk); #1;
            er  = (c >= 6 && c < 36) ? 4'b0100 : 4'b0000;
            ep  = (c == 6)  ? 4'b0100 : 4'b0000;
            el  = (c == 16) ? 4'b0100 : 4'b0000;
            erl = (c == 36) ? 4'b0100 : 4'b0000;
            checks++;
            if ({result, press, rel, lp} !== {er, ep, erl, el}) begin
                errors++;
                $display("FAIL long_press c=%0d got r=%b p=%b rl=%b l=%b exp r=%b p=%b rl=%b l=%b",
                         c, result, press, rel, lp, er, ep, erl, el);
            end
        end
    endtask

    task automatic test_inverted;
        logic [3:0] er, ep, erl;
        for (int c = 0; c <= 20; c++) begin
            button[3] = (c < 10) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            er  = (c >= 6 && c < 16) ? 4'b1000 : 4'b0000;
            ep  = (c == 6)  ? 4'b1000 : 4'b0000;
            erl = (c == 16) ? 4'b1000 : 4'b0000;
            checks++;
            if ({result, press, rel, lp} !== {er, ep, erl, 4'b0000}) begin
                errors++;
                $display("FAIL inverted c=%0d got r=%b p=%b rl=%b l=%b exp r=%b p=%b rl=%b l=0000",
                         c, result, press, rel, lp, er, ep, erl);
            end
        end
    endtask

    task automatic test_simultaneous_reset;
        logic [3:0] er, ep, el;
        for (int c = 0; c <= 20; c++) begin
            button[1:0] = 2'b11;
            if (c == 18) button[2] = 1'b1;
            @(posedge clk); #1;
            er = (c >= 6)  ? 4'b0011 : 4'b0000;
            ep = (c == 6)  ? 4'b0011 : 4'b0000;
            el = (c == 16) ? 4'b0011 : 4'b0000;
            checks++;
            if ({result, press, rel, lp} !== {er, ep, 4'b0000, el}) begin
                errors++;
                $display("FAIL simultaneous c=%0d got r=%b p=%b rl=%b l=%b exp r=%b p=%b rl=0000 l=%b",
                         c, result, press, rel, lp, er, ep, el);
            end
        end
        // Channels 0/1 are HELD and channel 2 is pending; reset lands mid-cycle.
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({result, press, rel, lp} !== 16'h0) begin
            errors++;
            $display("FAIL reset_async got r=%b p=%b rl=%b l=%b exp all 0", result, press, rel, lp);
        end
        button = 4'b1000;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({result, press, rel, lp} !== 16'h0) begin
                errors++;
                $display("FAIL reset_no_release c=%0d got r=%b p=%b rl=%b l=%b exp all 0",
                         c, result, press, rel, lp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_inverted();
        test_simultaneous_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Multi-channel button debouncer with edge and long-press event generation, parametrised in channel count, input polarity, stable time and long-press time. Each channel synchronises its raw pin, qualifies it through a per-channel state machine, and produces a clean level plus single-cycle press, release and long-press pulses. It sits between the board push-buttons/switches and the control FSMs, replacing per-button debounce instances with one bank.

## Interface
- `CHANNELS`, 4: number of independent inputs (≥1).
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `STABLE_MS`, 50: time in ms an input must stay constant before the level changes (≥1).
- `LONG_MS`, 1000: time in ms a press must last to raise `long_press`; 0 disables long-press.
- `INVERT`, '0: CHANNELS-bit mask; bit i=1 means channel i is active-low at the pin.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `button` input CHANNELS: raw, asynchronous pin levels.
- `result` output CHANNELS: debounced level, 1 = pressed (after polarity correction).
- `press` output CHANNELS: 1-cycle pulse when `result[i]` rises.
- `release` output CHANNELS: 1-cycle pulse when `result[i]` falls.
- `long_press` output CHANNELS: 1-cycle pulse once per press when held for LONG_CYC.

## Operation
- Derived constants: STABLE_CYC = CLK_FREQ/1000*STABLE_MS, LONG_CYC = CLK_FREQ/1000*LONG_MS, computed in 64-bit arithmetic, then narrowed; elaboration error if STABLE_CYC = 0 or either exceeds 2^31-1.
- Per channel: `x = button[i] ^ INVERT[i]`, then two-flop synchroniser → `s`. Both flops reset to 0.
- States: RELEASED, PRESS_PEND, PRESSED, HELD, RELEASE_PEND.
  - RELEASED: s=1 → PRESS_PEND, stable count cleared.
  - PRESS_PEND: s=0 → RELEASED. s=1 and count = STABLE_CYC-1 → PRESSED, `press` pulses, hold count cleared. Otherwise count+1.
  - PRESSED: s=0 → RELEASE_PEND (count cleared). Else hold count+1; if LONG_CYC≠0 and hold count reaches LONG_CYC-1 → HELD, `long_press` pulses.
  - HELD: s=0 → RELEASE_PEND. No further long pulses.
  - RELEASE_PEND: s=1 → back to HELD if long already fired, else PRESSED (hold count kept, not incremented while pending). s=0 and count = STABLE_CYC-1 → RELEASED, `release` pulses. Otherwise count+1.
- `result` = 1 in PRESSED, HELD, RELEASE_PEND; 0 otherwise.
- Counters saturate; stable counter width $clog2(STABLE_CYC+1), hold counter width $clog2(LONG_CYC+1) (min 1).
- Channels are fully independent; simultaneous events on several channels all pulse in the same cycle.

## Timing
- Reset: all outputs 0, all channels RELEASED, counters 0; takes effect immediately, no pulses emitted on or after reset release until a new qualified edge.
- Press latency: pin change at cycle 0 with `s` stable → `result` and `press` change exactly 2 + STABLE_CYC cycles later.
- Release latency identical. Long-press pulse LONG_CYC cycles after the `press` pulse when never bounced.
- A glitch shorter than STABLE_CYC cycles at `s` produces no output change.
- All outputs registered; pulses exactly one cycle wide.
- Reset asserted mid-PRESS_PEND or mid-HELD: outputs drop to 0 same cycle, no `release` pulse.

## Structure
- `debounce_pkg`: state enum `db_state_t`, function `ms_to_cycles(freq, ms)` (64-bit), constant widths helper.
- Sub-module `debounce_channel`: synchroniser, FSM, counters for one channel; `debounce_bank` is a generate loop of CHANNELS instances plus parameter checks.

## Test plan
Bench params CLK_FREQ=1000, STABLE_MS=4, LONG_MS=10, CHANNELS=4, INVERT=4'b1000 (STABLE_CYC=4, LONG_CYC=10).
- Clean press ch0 at cycle 0 → `result[0]`=1 and `press[0]` pulse at cycle 6; release held → `release[0]` 6 cycles after pin fall.
- Bounce ch1: 1 for 3 cycles, 0 for 1, then 1 steady → no output for glitch; `press[1]` 6 cycles after final rise.
- Hold ch2 for 30 cycles → `press` at 6, single `long_press` at 16, `release` 6 cycles after fall.
- Inverted ch3 pin idle 1 → `result[3]`=0; pin low → `press[3]` at +6.
- Simultaneous press ch0/ch1 same cycle → both `press` bits pulse same cycle; reset asserted mid-HELD → all outputs 0 immediately, no `release`.
